// File: rtl/object_spawn_sequencer_pkg.sv
// Shared pattern-ROM entry layout and sequencer state encoding for the object spawn pipeline.
package object_spawn_sequencer_pkg;

    localparam int ENTRY_WIDTH = 68;

    // Entry field offsets, LSB first; bits above LAST_BIT are reserved.
    localparam int WAIT_LSB    = 0;
    localparam int DIR_LSB     = 8;
    localparam int POS_X_LSB   = 11;
    localparam int POS_Y_LSB   = 21;
    localparam int SPEED_LSB   = 31;
    localparam int W_LSB       = 36;
    localparam int H_LSB       = 46;
    localparam int DTIME_LSB   = 56;
    localparam int TRIG_LSB    = 64;
    localparam int LAST_BIT    = 66;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_DELAY     = 3'd3,
        ST_WAIT_FREE = 3'd4,
        ST_SPAWN     = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [2:0] dir;
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic [4:0] speed;
        logic [9:0] w;
        logic [9:0] h;
        logic [7:0] destroy_time;
        logic [1:0] trigger;
    } spawn_fields_t;

    typedef struct packed {
        logic [7:0]    wait_cs;
        spawn_fields_t fields;
        logic          last;
    } pattern_entry_t;

    function automatic pattern_entry_t decode_entry(input logic [LAST_BIT:0] word);
        pattern_entry_t e;
        e.wait_cs             = word[WAIT_LSB  +: 8];
        e.fields.dir          = word[DIR_LSB   +: 3];
        e.fields.pos_x        = word[POS_X_LSB +: 10];
        e.fields.pos_y        = word[POS_Y_LSB +: 10];
        e.fields.speed        = word[SPEED_LSB +: 5];
        e.fields.w            = word[W_LSB     +: 10];
        e.fields.h            = word[H_LSB     +: 10];
        e.fields.destroy_time = word[DTIME_LSB +: 8];
        e.fields.trigger      = word[TRIG_LSB  +: 2];
        e.last                = word[LAST_BIT];
        return e;
    endfunction

endpackage

// File: rtl/object_spawn_sequencer.sv
// Walks a spawn pattern in the external pattern ROM, emitting one active-low load strobe per
// entry once its centisecond delay has elapsed and the downstream object slot is free.
module object_spawn_sequencer
    import object_spawn_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int ENTRY_W = ENTRY_WIDTH
) (
    input  logic               clk_centi_second,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    input  logic               object_free,
    output logic               sync_object_position,
    output logic [2:0]         movement_direction,
    output logic [9:0]         object_pos_x,
    output logic [9:0]         object_pos_y,
    output logic [9:0]         object_w,
    output logic [9:0]         object_h,
    output logic [4:0]         object_speed,
    output logic [7:0]         object_destroy_time,
    output logic [1:0]         object_destroy_trigger,
    output logic               busy,
    output logic               done
);

    seq_state_e     state_q, state_d;
    logic [7:0]     wait_q;
    spawn_fields_t  entry_fields_q;
    logic           entry_last_q;
    spawn_fields_t  spawn_q;
    logic           sync_n_q;
    pattern_entry_t rom_entry;
    logic           unused_reserved;

    assign rom_entry       = decode_entry(rom_data[LAST_BIT:0]);
    assign unused_reserved = ^rom_data[ENTRY_W-1:LAST_BIT+1];

    // NOTE: state_d defaults to state_q before the case so every path assigns it and no latch forms.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_LATCH;
            ST_LATCH:     state_d = ST_DELAY;
            ST_DELAY:     if (wait_q == 8'd0) state_d = ST_WAIT_FREE;
            ST_WAIT_FREE: if (object_free) state_d = ST_SPAWN;
            ST_SPAWN:     state_d = (entry_last_q || rom_addr == '1) ? ST_DONE : ST_FETCH;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // Abort beats every other transition while a pattern is in flight.
        if (abort && state_q != ST_IDLE && state_q != ST_DONE) state_d = ST_DONE;
    end

    // NOTE: reset is synchronous and clears every register here; none of them is a memory array.
    always_ff @(posedge clk_centi_second) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rom_addr       <= '0;
            wait_q         <= '0;
            entry_fields_q <= '0;
            entry_last_q   <= 1'b0;
            spawn_q        <= '0;
            sync_n_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values.
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_FETCH) rom_addr <= start_addr;
            if (state_q == ST_SPAWN && state_d == ST_FETCH) rom_addr <= rom_addr + 1'b1;
            if (state_q == ST_LATCH && state_d == ST_DELAY) begin
                entry_fields_q <= rom_entry.fields;
                entry_last_q   <= rom_entry.last;
                wait_q         <= rom_entry.wait_cs;
            end
            if (state_q == ST_DELAY && state_d == ST_DELAY) wait_q <= wait_q - 8'd1;
            // Spawn fields only change on entry to SPAWN and then hold until the next spawn.
            if (state_d == ST_SPAWN) spawn_q <= entry_fields_q;
            sync_n_q <= (state_d != ST_SPAWN);
        end
    end

    assign sync_object_position   = sync_n_q;
    assign movement_direction     = spawn_q.dir;
    assign object_pos_x           = spawn_q.pos_x;
    assign object_pos_y           = spawn_q.pos_y;
    assign object_w               = spawn_q.w;
    assign object_h               = spawn_q.h;
    assign object_speed           = spawn_q.speed;
    assign object_destroy_time    = spawn_q.destroy_time;
    assign object_destroy_trigger = spawn_q.trigger;
    assign busy                   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done                   = (state_q == ST_DONE);

endmodule

// File: tb/tb_object_spawn_sequencer.sv
// Scoreboard bench for object_spawn_sequencer: stimulus predicts strobe/done cycles and spawn
// fields from the entry timing rules; a negedge monitor pops and compares whenever the DUT acts.
module tb_object_spawn_sequencer;

    logic        clk_centi_second = 1'b0;
    logic        reset, start, abort, object_free;
    logic [7:0]  start_addr, rom_addr;
    logic [67:0] rom_data;
    logic        sync_object_position, busy, done;
    logic [2:0]  movement_direction;
    logic [9:0]  object_pos_x, object_pos_y, object_w, object_h;
    logic [4:0]  object_speed;
    logic [7:0]  object_destroy_time;
    logic [1:0]  object_destroy_trigger;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [67:0] rom_mem [256];

    typedef struct {
        int          cyc;
        logic [57:0] fields;
    } spawn_exp_t;

    spawn_exp_t exp_spawn[$];
    int         exp_done[$];
    spawn_exp_t mon_item;
    logic [57:0] obs;

    assign obs = {movement_direction, object_pos_x, object_pos_y, object_speed,
                  object_w, object_h, object_destroy_time, object_destroy_trigger};

    object_spawn_sequencer dut (
        .clk_centi_second       (clk_centi_second),
        .reset                  (reset),
        .start                  (start),
        .abort                  (abort),
        .start_addr             (start_addr),
        .rom_addr               (rom_addr),
        .rom_data               (rom_data),
        .object_free            (object_free),
        .sync_object_position   (sync_object_position),
        .movement_direction     (movement_direction),
        .object_pos_x           (object_pos_x),
        .object_pos_y           (object_pos_y),
        .object_w               (object_w),
        .object_h               (object_h),
        .object_speed           (object_speed),
        .object_destroy_time    (object_destroy_time),
        .object_destroy_trigger (object_destroy_trigger),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk_centi_second = ~clk_centi_second;

    // Pattern ROM with one cycle of read latency; cyc counts active edges.
    always @(posedge clk_centi_second) begin
        rom_data <= rom_mem[rom_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_centi_second) begin
        if (sync_object_position === 1'b0) begin
            if (exp_spawn.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                mon_item = exp_spawn.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(mon_item.cyc));
                check("spawn_fields", 64'(obs), 64'(mon_item.fields));
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        end
    end

    // Writes one random entry into the ROM and returns its expected spawn fields.
    task automatic load_entry(input int addr, input logic [7:0] wt, input logic lst,
                              output logic [57:0] f);
        logic [2:0] d;
        logic [9:0] x, y, w, h;
        logic [4:0] sp;
        logic [7:0] dt;
        logic [1:0] tr;
        logic       rsv;
        d = 3'($urandom); x = 10'($urandom); y = 10'($urandom); w = 10'($urandom);
        h = 10'($urandom); sp = 5'($urandom); dt = 8'($urandom); tr = 2'($urandom);
        rsv = 1'($urandom);
        rom_mem[addr] = {rsv, lst, tr, dt, h, w, sp, y, x, d, wt};
        f = {d, x, y, sp, w, h, dt, tr};
    endtask

    // Strobe k of a pattern lands 4 + wait_0 edges after start, then 5 + wait_k after the previous
    // one (SPAWN, FETCH, LATCH, DELAY, WAIT_FREE); done follows the final strobe by one edge.
    task automatic issue_pattern(input int addr, input int n, input int min_w, input int max_w,
                                 input bit mark_last, input bit poke);
        int          t;
        logic [57:0] f;
        logic [7:0]  wt;
        int          waits[$];
        logic [57:0] flds[$];
        spawn_exp_t  item;
        for (int i = 0; i < n; i++) begin
            wt = 8'($urandom_range(max_w, min_w));
            load_entry(addr + i, wt, mark_last && (i == n - 1), f);
            waits.push_back(int'(wt));
            flds.push_back(f);
        end
        @(negedge clk_centi_second);
        start = 1'b1;
        start_addr = 8'(addr);
        t = cyc + 1;
        for (int i = 0; i < n; i++) begin
            t = t + ((i == 0) ? 4 : 5) + waits[i];
            item.cyc = t;
            item.fields = flds[i];
            exp_spawn.push_back(item);
        end
        exp_done.push_back(t + 1);
        @(negedge clk_centi_second);
        start = 1'b0;
        start_addr = 8'($urandom);
        if (poke) begin
            @(negedge clk_centi_second);
            start = 1'b1;
            @(negedge clk_centi_second);
            start = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int exp_addr);
        int n;
        n = 0;
        while ((exp_spawn.size() != 0 || exp_done.size() != 0) && n < 3000) begin
            @(negedge clk_centi_second);
            n++;
        end
        check({name, "_drained"}, 64'(exp_spawn.size() + exp_done.size()), 64'd0);
        repeat (3) @(negedge clk_centi_second);
        check({name, "_rom_addr"}, 64'(rom_addr), 64'(exp_addr));
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [57:0] f, f2;
        int          n, a, k;
        spawn_exp_t  item;

        for (int i = 0; i < 256; i++) rom_mem[i] = '0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; object_free = 1'b1;
        repeat (3) @(negedge clk_centi_second);
        check("reset_rom_addr", 64'(rom_addr), 64'd0);
        check("reset_sync", 64'(sync_object_position), 64'd1);
        check("reset_fields", 64'(obs), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk_centi_second);

        // Single entry, wait 3, from address 5: strobe 7 edges after start.
        issue_pattern(5, 1, 3, 3, 1'b1, 1'b0);
        wait_idle("single", 5);

        // Three back-to-back zero-wait entries.
        issue_pattern(10, 3, 0, 0, 1'b1, 1'b0);
        wait_idle("triple", 12);

        // Slot busy for 20 cycles: strobe one edge after object_free rises.
        object_free = 1'b0;
        load_entry(60, 8'd0, 1'b1, f);
        @(negedge clk_centi_second);
        start = 1'b1; start_addr = 8'd60;
        @(negedge clk_centi_second);
        start = 1'b0;
        repeat (20) @(negedge clk_centi_second);
        item.cyc = cyc + 1;
        item.fields = f;
        exp_spawn.push_back(item);
        exp_done.push_back(cyc + 2);
        object_free = 1'b1;
        wait_idle("free_hold", 60);

        // Abort during a long delay: done next edge, no strobe.
        load_entry(80, 8'd200, 1'b1, f);
        @(negedge clk_centi_second);
        start = 1'b1; start_addr = 8'd80;
        @(negedge clk_centi_second);
        start = 1'b0;
        repeat (8) @(negedge clk_centi_second);
        abort = 1'b1;
        exp_done.push_back(cyc + 1);
        @(negedge clk_centi_second);
        abort = 1'b0;
        wait_idle("abort", 80);

        // Top of the address space with last=0: one strobe then done, no wrap.
        issue_pattern(255, 1, 0, 5, 1'b0, 1'b0);
        wait_idle("top_addr", 255);

        // Randomized patterns, each with a start pulse issued mid-pattern that must be ignored.
        for (k = 0; k < 8; k++) begin
            n = $urandom_range(4, 1);
            a = $urandom_range(250, 0);
            issue_pattern(a, n, 0, 6, 1'b1, 1'b1);
            wait_idle("random", a + n - 1);
        end

        // Reset while in SPAWN, with start held high during reset.
        load_entry(40, 8'd1, 1'b0, f);
        load_entry(41, 8'd0, 1'b1, f2);
        @(negedge clk_centi_second);
        start = 1'b1; start_addr = 8'd40;
        item.cyc = cyc + 1 + 4 + 1;
        item.fields = f;
        exp_spawn.push_back(item);
        @(negedge clk_centi_second);
        start = 1'b0;
        n = 0;
        while (sync_object_position !== 1'b0 && n < 50) begin
            @(negedge clk_centi_second);
            n++;
        end
        check("reset_test_strobe_seen", 64'(sync_object_position), 64'd0);
        reset = 1'b1; start = 1'b1; start_addr = 8'd7;
        @(negedge clk_centi_second);
        check("midreset_sync", 64'(sync_object_position), 64'd1);
        check("midreset_fields", 64'(obs), 64'd0);
        check("midreset_rom_addr", 64'(rom_addr), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk_centi_second);
        reset = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk_centi_second);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_rom_addr", 64'(rom_addr), 64'd0);
        check("post_reset_queues", 64'(exp_spawn.size() + exp_done.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
